// File: rtl/arp_reply_tx.sv
// ARP reply framer: turns an arp_send pulse into a serialised Ethernet ARP reply
// (opcode 2) on a valid/ready byte stream. Holds one request pending while a frame
// is in flight and enforces an inter-frame gap after every frame.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no frame; start on arp_send or a held pending request
// SEND   | presenting frame byte cnt_q; advances on tx_valid && tx_ready
// GAP    | forced idle after the last byte, gap_q counts down to zero
module arp_reply_tx #(
  parameter bit PAD_MIN    = 1'b1,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  input  logic        arp_send,
  input  logic [47:0] source_mac,
  input  logic [31:0] source_ip,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  data_tx,
  output logic        tx_last,
  output logic        busy,
  output logic        req_drop
);

  // gap_q only ever holds IFG_CYCLES-1 down to 0
  localparam int              GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(IFG_CYCLES - 1);
  localparam logic [5:0]      LAST_IDX = PAD_MIN ? 6'd59 : 6'd41;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [47:0]   dst_mac_q, dst_mac_d;
  logic [31:0]   dst_ip_q, dst_ip_d;
  logic [47:0]   my_mac_q, my_mac_d;
  logic [31:0]   my_ip_q, my_ip_d;
  logic          pend_vld_q, pend_vld_d;
  logic [47:0]   pend_mac_q, pend_mac_d;
  logic [31:0]   pend_ip_q, pend_ip_d;
  logic          req_drop_q, req_drop_d;

  logic [335:0]  frame_w;
  logic [8:0]    bit_off;

  // Next-state logic for the sequencer, frame registers and the pending slot
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    dst_mac_d  = dst_mac_q;
    dst_ip_d   = dst_ip_q;
    my_mac_d   = my_mac_q;
    my_ip_d    = my_ip_q;
    pend_vld_d = pend_vld_q;
    pend_mac_d = pend_mac_q;
    pend_ip_d  = pend_ip_q;
    req_drop_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          // older request goes first; a simultaneous new one refills the slot
          dst_mac_d  = pend_mac_q;
          dst_ip_d   = pend_ip_q;
          my_mac_d   = my_mac;
          my_ip_d    = my_ip;
          cnt_d      = 6'd0;
          state_d    = S_SEND;
          pend_vld_d = arp_send;
          if (arp_send) begin
            pend_mac_d = source_mac;
            pend_ip_d  = source_ip;
          end
        end else if (arp_send) begin
          dst_mac_d = source_mac;
          dst_ip_d  = source_ip;
          my_mac_d  = my_mac;
          my_ip_d   = my_ip;
          cnt_d     = 6'd0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 6'd0;
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && arp_send) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_mac_d = source_mac;
        pend_ip_d  = source_ip;
      end else begin
        req_drop_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset aborts any frame and clears the slot
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      gap_q      <= '0;
      dst_mac_q  <= 48'd0;
      dst_ip_q   <= 32'd0;
      my_mac_q   <= 48'd0;
      my_ip_q    <= 32'd0;
      pend_vld_q <= 1'b0;
      pend_mac_q <= 48'd0;
      pend_ip_q  <= 32'd0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      dst_mac_q  <= dst_mac_d;
      dst_ip_q   <= dst_ip_d;
      my_mac_q   <= my_mac_d;
      my_ip_q    <= my_ip_d;
      pend_vld_q <= pend_vld_d;
      pend_mac_q <= pend_mac_d;
      pend_ip_q  <= pend_ip_d;
      req_drop_q <= req_drop_d;
    end
  end

  // 42 header/payload bytes, byte 0 in the top octet; padding bytes are zero
  assign frame_w = {dst_mac_q, my_mac_q, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                    16'h0002, my_mac_q, my_ip_q, dst_mac_q, dst_ip_q};
  assign bit_off = {3'b000, 6'd41 - cnt_q} << 3;

  // Byte mux; outputs decode straight from registers so reset clears them at once
  always_comb begin
    data_tx = 8'h00;
    if ((state_q == S_SEND) && (cnt_q <= 6'd41)) data_tx = frame_w[bit_off +: 8];
  end

  assign tx_valid = (state_q == S_SEND);
  assign tx_last  = (state_q == S_SEND) && (cnt_q == LAST_IDX);
  assign busy     = (state_q != S_IDLE) || pend_vld_q;
  assign req_drop = req_drop_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Bench for arp_reply_tx: a padded (60 B) and an unpadded (42 B) instance share stimulus.
module tb_arp_reply_tx;

  localparam logic [47:0] MYMAC = 48'h0200_0000_0001;
  localparam logic [31:0] MYIP  = 32'hC0A8_0102;
  localparam logic [47:0] SMAC  = 48'h0001_4200_5F68;
  localparam logic [31:0] IP1   = 32'hC0A8_0101;
  localparam logic [31:0] IP3   = 32'hC0A8_0103;
  localparam logic [31:0] IP4   = 32'hC0A8_0104;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [47:0] my_mac = MYMAC;
  logic [31:0] my_ip = MYIP;
  logic        arp_send = 1'b0;
  logic [47:0] source_mac = 48'd0;
  logic [31:0] source_ip = 32'd0;
  logic        tx_ready = 1'b0;

  logic        v0, l0, b0, r0;
  logic [7:0]  d0;
  logic        v1, l1, b1, r1;
  logic [7:0]  d1;

  arp_reply_tx #(.PAD_MIN(1'b1), .IFG_CYCLES(12)) dut (
    .clk(clk), .areset(areset), .my_mac(my_mac), .my_ip(my_ip), .arp_send(arp_send),
    .source_mac(source_mac), .source_ip(source_ip), .tx_ready(tx_ready),
    .tx_valid(v0), .data_tx(d0), .tx_last(l0), .busy(b0), .req_drop(r0));

  arp_reply_tx #(.PAD_MIN(1'b0), .IFG_CYCLES(12)) dut42 (
    .clk(clk), .areset(areset), .my_mac(my_mac), .my_ip(my_ip), .arp_send(arp_send),
    .source_mac(source_mac), .source_ip(source_ip), .tx_ready(tx_ready),
    .tx_valid(v1), .data_tx(d1), .tx_last(l1), .busy(b1), .req_drop(r1));

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic l; int c;} acc_t;
  typedef struct {int idx; logic [7:0] d; logic l;} spot_t;

  acc_t  q0[$];
  acc_t  q1[$];
  int    starts[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    drop_cnt = 0;
  logic  stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic  valid_prev = 1'b0;
  logic  bp_en = 1'b0;
  logic  rdy_force = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [47:0] sm,
                                          input logic [31:0] si, input logic [47:0] mm,
                                          input logic [31:0] mi);
    logic [79:0] hdr;
    logic [7:0]  b;
    hdr = 80'h0806_0001_0800_0604_0002;
    b = 8'h00;
    if (i < 6)       b = sm[47-8*i -: 8];
    else if (i < 12) b = mm[47-8*(i-6) -: 8];
    else if (i < 22) b = hdr[79-8*(i-12) -: 8];
    else if (i < 28) b = mm[47-8*(i-22) -: 8];
    else if (i < 32) b = mi[31-8*(i-28) -: 8];
    else if (i < 38) b = sm[47-8*(i-32) -: 8];
    else if (i < 42) b = si[31-8*(i-38) -: 8];
    return b;
  endfunction

  // tx_ready source: forced level or pseudo-random backpressure
  always @(posedge clk) begin
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    tx_ready = bp_en ? lfsr[0] : rdy_force;
  end

  // Monitor: accepted bytes, frame starts, drops, and hold-under-stall
  always @(negedge clk) begin
    cyc++;
    if (stall_prev) chk("stall_hold", {55'd0, v0, d0}, {55'd0, 1'b1, stall_data});
    stall_prev = v0 && !tx_ready;
    stall_data = d0;
    if (v0 && tx_ready) q0.push_back('{d: d0, l: l0, c: cyc});
    if (v1 && tx_ready) q1.push_back('{d: d1, l: l1, c: cyc});
    if (v0 && !valid_prev) starts.push_back(cyc);
    valid_prev = v0;
    if (r0) drop_cnt++;
  end

  task automatic pulse_req(input logic [31:0] ip);
    @(posedge clk); #1;
    arp_send = 1'b1; source_mac = SMAC; source_ip = ip;
    @(posedge clk); #1;
    arp_send = 1'b0; source_mac = 48'hDEAD_BEEF_0BAD; source_ip = 32'h1234_5678;
  endtask

  task automatic wait_acc(input int n0, input int n1, input int budget);
    int k;
    k = 0;
    while ((q0.size() < n0 || q1.size() < n1) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (k >= budget) begin
      n_total++;
      $display("FAIL timeout: q0=%0d q1=%0d want %0d/%0d", q0.size(), q1.size(), n0, n1);
    end
  endtask

  task automatic chk_frame(input bit which, input int base, input int len, input logic [31:0] si);
    acc_t e;
    for (int i = 0; i < len; i++) begin
      if (which) e = (base + i < q1.size()) ? q1[base+i] : '{d: 8'hxx, l: 1'bx, c: 0};
      else       e = (base + i < q0.size()) ? q0[base+i] : '{d: 8'hxx, l: 1'bx, c: 0};
      chk($sformatf("frame%0d_byte[%0d]", which ? 42 : 60, base + i), {55'd0, e.l, e.d},
          {55'd0, (i == len - 1), exp_byte(i, SMAC, si, MYMAC, MYIP)});
    end
  endtask

  spot_t spot[16];
  int    nst;

  initial begin
    spot[0]  = '{0, 8'h00, 1'b0};  spot[1]  = '{1, 8'h01, 1'b0};
    spot[2]  = '{2, 8'h42, 1'b0};  spot[3]  = '{3, 8'h00, 1'b0};
    spot[4]  = '{4, 8'h5F, 1'b0};  spot[5]  = '{5, 8'h68, 1'b0};
    spot[6]  = '{12, 8'h08, 1'b0}; spot[7]  = '{13, 8'h06, 1'b0};
    spot[8]  = '{20, 8'h00, 1'b0}; spot[9]  = '{21, 8'h02, 1'b0};
    spot[10] = '{38, 8'hC0, 1'b0}; spot[11] = '{39, 8'hA8, 1'b0};
    spot[12] = '{40, 8'h01, 1'b0}; spot[13] = '{41, 8'h01, 1'b0};
    spot[14] = '{58, 8'h00, 1'b0}; spot[15] = '{59, 8'h00, 1'b1};

    // Reset held three cycles, then quiet idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {v0, d0, l0, b0, r0}, 12'h000);
    chk("rst_outputs42", {v1, d1, l1, b1, r1}, 12'h000);
    @(posedge clk); #1 areset = 1'b0;
    rdy_force = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_quiet", {v0, b0, v1, b1}, 4'h0);
    end

    // Basic frame with tx_ready high, one-cycle latency
    q0.delete(); q1.delete();
    pulse_req(IP1);
    @(negedge clk);
    chk("latency_byte0", {v0, d0, l0}, {1'b1, 8'h00, 1'b0});
    chk("busy_in_frame", b0, 1'b1);
    wait_acc(60, 42, 200);
    chk("frame60_len", q0.size(), 60);
    for (int i = 0; i < 16; i++)
      chk($sformatf("spot[%0d]", spot[i].idx), {55'd0, q0[spot[i].idx].l, q0[spot[i].idx].d},
          {55'd0, spot[i].l, spot[i].d});
    chk_frame(1'b0, 0, 60, IP1);
    repeat (30) @(posedge clk);

    // Backpressure, and my_mac/my_ip change after the frame has started
    q0.delete(); q1.delete();
    bp_en = 1'b1;
    pulse_req(IP1);
    my_mac = 48'hAABB_CCDD_EEFF; my_ip = 32'h0A0A_0A0A;
    wait_acc(60, 42, 600);
    my_mac = MYMAC; my_ip = MYIP;
    bp_en = 1'b0;
    chk("bp_len60", q0.size(), 60);
    chk("bp_len42", q1.size(), 42);
    chk_frame(1'b0, 0, 60, IP1);
    chk_frame(1'b1, 0, 42, IP1);
    repeat (30) @(posedge clk);

    // Queueing: .01 starts, .03 pends, .04 is dropped
    q0.delete(); q1.delete(); starts.delete();
    drop_cnt = 0;
    pulse_req(IP1);
    repeat (5) @(posedge clk);
    pulse_req(IP3);
    @(negedge clk);
    chk("drop_none_yet", r0, 1'b0);
    repeat (5) @(posedge clk);
    pulse_req(IP4);
    @(negedge clk);
    chk("drop_pulse", r0, 1'b1);
    @(negedge clk);
    chk("drop_one_cycle", r0, 1'b0);
    wait_acc(120, 0, 400);
    repeat (150) @(posedge clk);
    chk("queue_total_bytes", q0.size(), 120);
    chk("queue_frames", starts.size(), 2);
    chk("drop_count", drop_cnt, 1);
    chk_frame(1'b0, 0, 60, IP1);
    chk_frame(1'b0, 60, 60, IP3);
    // 12 GAP cycles plus the IDLE cycle that launches the pending frame
    if (starts.size() >= 2 && q0.size() >= 60)
      chk("gap_cycles", starts[1] - q0[59].c - 1, 13);
    chk("idle_after_queue", {v0, b0}, 2'b00);

    // Abort at byte 20 with a request pending
    q0.delete(); starts.delete();
    pulse_req(IP1);
    pulse_req(IP3);
    wait_acc(20, 0, 200);
    nst = starts.size();
    chk("abort_busy_before", b0, 1'b1);
    #2 areset = 1'b1;
    #1;
    chk("abort_outputs", {v0, d0, l0, b0, r0}, 12'h000);
    @(posedge clk); @(posedge clk); #1 areset = 1'b0;
    repeat (80) @(posedge clk);
    chk("abort_no_resume", q0.size(), 20);
    chk("abort_no_pending_frame", starts.size(), nst);
    @(negedge clk);
    chk("abort_idle", {v0, b0, v1, b1}, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
